// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase sequencer: phase encoding and
// the bit positions of the lamp vector used by the controller and its bench.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN,
    MAIN_YELLOW,
    ALL_RED,
    SIDE_GREEN,
    SIDE_YELLOW,
    WALK,
    WALK_CLEAR
  } state_e;

  localparam int LAMP_MAIN_RED    = 0;
  localparam int LAMP_MAIN_YELLOW = 1;
  localparam int LAMP_MAIN_GREEN  = 2;
  localparam int LAMP_SIDE_RED    = 3;
  localparam int LAMP_SIDE_YELLOW = 4;
  localparam int LAMP_SIDE_GREEN  = 5;
  localparam int LAMP_WALK        = 6;
  localparam int LAMP_DONT_WALK   = 7;
  localparam int LAMP_N           = 8;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter for phase dwell times; saturates at zero and flags
// expiry while it reads zero.
module phase_timer #(
  parameter int CNT_W   = 8,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             sys_reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    if (load)              cnt_d = load_val;
    else if (cnt_q == '0)  cnt_d = '0;
    else                   cnt_d = cnt_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!sys_reset) cnt_q <= CNT_W'(RST_VAL);
    else            cnt_q <= cnt_d;
  end

  assign count   = cnt_q;
  assign expired = (cnt_q == '0);

endmodule

// File: rtl/traffic_phase_controller.sv
// Timed Moore sequencer for vehicle and pedestrian lamps with walk-request ack.
// Optional don't-walk flashing during pedestrian clearance: WALK_FLASH_EN.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int GREEN_MIN  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int RED_CYC    = 2,
  parameter int SIDE_CYC   = 5,
  parameter int WALK_CYC   = 6,
  parameter int CLEAR_CYC  = 4,
  parameter int FLASH_CYC  = 2
) (
  input  logic clk,
  input  logic sys_reset,
  input  logic walkRegister_status,
  input  logic side_car_sensor,
  output logic main_red,
  output logic main_yellow,
  output logic main_green,
  output logic side_red,
  output logic side_yellow,
  output logic side_green,
  output logic walk_lamp,
  output logic dont_walk_lamp,
  output logic walkRegister_reset
);

  localparam int MAX_DUR = 2 ** CNT_W;

  if (GREEN_MIN < 1 || YELLOW_CYC < 1 || RED_CYC < 1 || SIDE_CYC < 1 ||
      WALK_CYC < 1 || CLEAR_CYC < 1 || FLASH_CYC < 1 ||
      GREEN_MIN >= MAX_DUR || YELLOW_CYC >= MAX_DUR || RED_CYC >= MAX_DUR ||
      SIDE_CYC >= MAX_DUR || WALK_CYC >= MAX_DUR || CLEAR_CYC >= MAX_DUR ||
      FLASH_CYC >= MAX_DUR) begin : g_bad_duration
    $error("traffic_phase_controller: every duration must be in 1 .. 2**CNT_W-1");
  end

  state_e           state_q, state_d;
  logic             goto_main_q, goto_main_d;
  logic             t_load, t_expired;
  logic [CNT_W-1:0] t_load_val, t_count;
  logic             dw_clear;
  logic [LAMP_N-1:0] lamps;

  function automatic logic [CNT_W-1:0] dwell_m1(input state_e s);
    case (s)
      MAIN_GREEN:  return CNT_W'(GREEN_MIN - 1);
      MAIN_YELLOW: return CNT_W'(YELLOW_CYC - 1);
      SIDE_GREEN:  return CNT_W'(SIDE_CYC - 1);
      SIDE_YELLOW: return CNT_W'(YELLOW_CYC - 1);
      WALK:        return CNT_W'(WALK_CYC - 1);
      WALK_CLEAR:  return CNT_W'(CLEAR_CYC - 1);
      default:     return CNT_W'(RED_CYC - 1);
    endcase
  endfunction

  // NOTE: defaults first keep every path assigned, so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    goto_main_d = goto_main_q;
    case (state_q)
      MAIN_GREEN:
        if (t_expired && (walkRegister_status || side_car_sensor)) state_d = MAIN_YELLOW;
      MAIN_YELLOW:
        if (t_expired) begin
          state_d     = ALL_RED;
          goto_main_d = 1'b0;
        end
      ALL_RED:
        if (t_expired) begin
          if (goto_main_q)              state_d = MAIN_GREEN;
          else if (walkRegister_status) state_d = WALK;
          else if (side_car_sensor)     state_d = SIDE_GREEN;
          else                          state_d = MAIN_GREEN;
        end
      SIDE_GREEN:
        if (t_expired) begin
          state_d     = SIDE_YELLOW;
          goto_main_d = 1'b1;
        end
      SIDE_YELLOW:
        if (t_expired) state_d = ALL_RED;
      WALK:
        if (t_expired) begin
          state_d     = WALK_CLEAR;
          goto_main_d = 1'b1;
        end
      WALK_CLEAR:
        if (t_expired) state_d = ALL_RED;
      default:
        state_d = ALL_RED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sys_reset) begin
      state_q     <= ALL_RED;
      goto_main_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      goto_main_q <= goto_main_d;
    end
  end

  // Every transition is a state change, so the timer reloads exactly on entry.
  assign t_load     = (state_d != state_q);
  assign t_load_val = dwell_m1(state_d);

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (RED_CYC - 1)
  ) u_timer (
    .clk       (clk),
    .sys_reset (sys_reset),
    .load      (t_load),
    .load_val  (t_load_val),
    .count     (t_count),
    .expired   (t_expired)
  );

`ifdef WALK_FLASH_EN
  logic [CNT_W-1:0] flash_cnt_q, flash_cnt_d;
  logic             flash_phase_q, flash_phase_d;

  // Both flash registers clear on any cycle not continuing WALK_CLEAR, which
  // covers both the reset on entry and the forced-on lamp after leaving.
  always_comb begin
    flash_cnt_d   = '0;
    flash_phase_d = 1'b0;
    if (state_q == WALK_CLEAR && state_d == WALK_CLEAR) begin
      if (flash_cnt_q == CNT_W'(FLASH_CYC - 1)) begin
        flash_phase_d = ~flash_phase_q;
      end else begin
        flash_cnt_d   = flash_cnt_q + 1'b1;
        flash_phase_d = flash_phase_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!sys_reset) begin
      flash_cnt_q   <= '0;
      flash_phase_q <= 1'b0;
    end else begin
      flash_cnt_q   <= flash_cnt_d;
      flash_phase_q <= flash_phase_d;
    end
  end

  assign dw_clear = ~flash_phase_q;
`else
  assign dw_clear = 1'b1;
`endif

  always_comb begin
    lamps                   = '0;
    lamps[LAMP_MAIN_GREEN]  = (state_q == MAIN_GREEN);
    lamps[LAMP_MAIN_YELLOW] = (state_q == MAIN_YELLOW);
    lamps[LAMP_MAIN_RED]    = !(state_q inside {MAIN_GREEN, MAIN_YELLOW});
    lamps[LAMP_SIDE_GREEN]  = (state_q == SIDE_GREEN);
    lamps[LAMP_SIDE_YELLOW] = (state_q == SIDE_YELLOW);
    lamps[LAMP_SIDE_RED]    = !(state_q inside {SIDE_GREEN, SIDE_YELLOW});
    lamps[LAMP_WALK]        = (state_q == WALK);
    lamps[LAMP_DONT_WALK]   = (state_q == WALK)       ? 1'b0 :
                              (state_q == WALK_CLEAR) ? dw_clear : 1'b1;
  end

  assign main_red       = lamps[LAMP_MAIN_RED];
  assign main_yellow    = lamps[LAMP_MAIN_YELLOW];
  assign main_green     = lamps[LAMP_MAIN_GREEN];
  assign side_red       = lamps[LAMP_SIDE_RED];
  assign side_yellow    = lamps[LAMP_SIDE_YELLOW];
  assign side_green     = lamps[LAMP_SIDE_GREEN];
  assign walk_lamp      = lamps[LAMP_WALK];
  assign dont_walk_lamp = lamps[LAMP_DONT_WALK];

  // The timer still holds its load value only in the first WALK cycle.
  assign walkRegister_reset = (state_q == WALK) && (t_count == CNT_W'(WALK_CYC - 1));

endmodule

// File: doc/traffic_phase_controller.md
# traffic_phase_controller

Phase sequencer for the intersection, directly downstream of the walk-request register. Consumes `walkRegister_status` and a side-road car sensor, and drives the vehicle and pedestrian lamps through a timed Moore state machine. Returns `walkRegister_reset` to the walk register when the pedestrian phase is granted, closing the request/acknowledge loop.

## Interface
Parameters:
- `CNT_W`, 8: width of the phase timer.
- `GREEN_MIN`, 8: minimum main-road green, in cycles.
- `YELLOW_CYC`, 3: yellow duration for either road.
- `RED_CYC`, 2: all-red clearance duration.
- `SIDE_CYC`, 5: side-road green duration.
- `WALK_CYC`, 6: walk lamp duration.
- `CLEAR_CYC`, 4: pedestrian clearance duration.
- `FLASH_CYC`, 2: don't-walk flash half-period. Used only with `WALK_FLASH_EN`.

All durations are ≥1 and < 2^CNT_W.

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `sys_reset`, in, 1: reset. Synchronous, active-low.
- `walkRegister_status`, in, 1: pending pedestrian request (level, held by the walk register).
- `side_car_sensor`, in, 1: side-road vehicle present (level).
- `main_red`, `main_yellow`, `main_green`, out, 1 each: main-road lamps.
- `side_red`, `side_yellow`, `side_green`, out, 1 each: side-road lamps.
- `walk_lamp`, `dont_walk_lamp`, out, 1 each: pedestrian lamps.
- `walkRegister_reset`, out, 1: one-cycle acknowledge that clears the walk register.

## Operation
- States: MAIN_GREEN, MAIN_YELLOW, ALL_RED, SIDE_GREEN, SIDE_YELLOW, WALK, WALK_CLEAR.
- On state entry, the timer loads duration−1. It decrements each cycle, and the state's dwell expires when the timer reads 0.
- MAIN_GREEN:
  - Holds at least GREEN_MIN cycles.
  - Once expired, moves to MAIN_YELLOW on the first cycle where `walkRegister_status | side_car_sensor` is 1.
  - If neither request is present, it holds indefinitely with the timer saturated at 0.
- MAIN_YELLOW → ALL_RED.
- ALL_RED: the next state is chosen by the 1-bit `goto_main` register.
  - `goto_main`=1: go to MAIN_GREEN.
  - `goto_main`=0 and walk pending at expiry: go to WALK. Walk has priority over side.
  - `goto_main`=0, no walk, side sensor high: go to SIDE_GREEN.
  - `goto_main`=0, both requests gone: go to MAIN_GREEN.
- `goto_main` is cleared on leaving MAIN_YELLOW and set on entering SIDE_YELLOW or WALK_CLEAR.
- SIDE_GREEN → SIDE_YELLOW → ALL_RED.
- WALK → WALK_CLEAR → ALL_RED.
- Lamp decode (Moore, from the state register):
  - Main green/yellow only in MAIN_GREEN/MAIN_YELLOW; `main_red` in all other states.
  - Side green/yellow only in SIDE_GREEN/SIDE_YELLOW; `side_red` otherwise.
  - `walk_lamp` only in WALK.
  - `dont_walk_lamp` in every state except WALK (WALK_CLEAR behaviour: see Configuration).
  - Exactly one lamp per road is lit at all times.
- `walkRegister_reset` = 1 only during the first cycle of WALK.
- Requests are sampled only at decision points: MAIN_GREEN exit and ALL_RED expiry. A walk request arriving during WALK/WALK_CLEAR is re-registered by the walk register and served in a later cycle of the sequence.
- Reset (`sys_reset`=0 at an edge), including mid-phase:
  - state ← ALL_RED, timer ← RED_CYC−1, `goto_main` ← 1, flash phase ← 0.
  - Outputs while in reset and afterwards: `main_red`=`side_red`=`dont_walk_lamp`=1, all other lamps 0, `walkRegister_reset`=0.

## Timing
- Every timed state lasts exactly its duration in cycles.
- Outputs change in the same cycle as the state register; there is no extra output latency.
- MAIN_GREEN with a request already present lasts exactly GREEN_MIN cycles.
- A request arriving after the minimum has elapsed causes exit one cycle after the request is first seen high.
- Walk latency from a request raised in MAIN_GREEN (minimum already expired) to `walk_lamp`: 1 + YELLOW_CYC + RED_CYC cycles.
- Request and acknowledge coincide: `walkRegister_reset` and the first `walk_lamp` cycle are the same cycle. `walkRegister_status` drops the following cycle and must not affect the WALK dwell.

## Configuration
- `WALK_FLASH_EN` defined:
  - In WALK_CLEAR, `dont_walk_lamp` starts at 1 and toggles every FLASH_CYC cycles, using a flash counter that is reset on WALK_CLEAR entry.
  - It is forced to 1 on leaving WALK_CLEAR.
- `WALK_FLASH_EN` undefined: `dont_walk_lamp` is steady 1 through WALK_CLEAR, and no flash logic is built.

## Structure
- Shared package `traffic_pkg`: the state enum typedef and lamp index constants, shared with the top level and the bench.
- One sub-module `phase_timer`:
  - Behaviour: loadable down-counter with saturate-at-0 and an `expired` output.
  - Interface: `clk`, `sys_reset`, `load`, `load_val[CNT_W]`.

## Test plan
All scenarios use the default parameters.
- Reset release → ALL_RED for 2 cycles, then MAIN_GREEN. `main_green` is high and all other main lamps low.
- No requests for 50 cycles → stays in MAIN_GREEN and `walkRegister_reset` never pulses.
- `walkRegister_status`=1 from cycle 0 of MAIN_GREEN:
  - Green lasts 8 cycles, then yellow 3, all-red 2, walk 6, clear 4, all-red 2, then MAIN_GREEN.
  - `walkRegister_reset` is high for exactly 1 cycle, at the walk start.
- Walk and side requests both high → WALK is served first. If the side sensor stays high, SIDE_GREEN follows on the next cycle through (5 cycles).
- With `WALK_FLASH_EN`, `dont_walk_lamp` over the 4 WALK_CLEAR cycles = 1,1,0,0.
- `sys_reset`=0 asserted during WALK cycle 3 → next edge shows the reset outputs. `walk_lamp`=0 immediately and the controller resumes via ALL_RED → MAIN_GREEN.
